// File: rtl/nco_pkg.sv
// Shared definitions for the NCO phase generator: default widths, config
// address map and control-register bit positions.
package nco_pkg;

  localparam int PW_DEF = 24;
  localparam int SW_DEF = 8;

  typedef enum logic [1:0] {
    CFG_FTW  = 2'd0,
    CFG_OFS  = 2'd1,
    CFG_STEP = 2'd2,
    CFG_CTRL = 2'd3
  } cfg_addr_e;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

  // Byte-counter width; a single-byte word still needs a 1-bit counter.
  function automatic int cnt_width(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/nco_cfg_loader.sv
// Byte-wide loader for the multi-byte FTW/offset words: LSB-first shadow,
// restart on target change, and a one-cycle ready gap after each commit.
module nco_cfg_loader
  import nco_pkg::*;
#(
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_valid,
  input  logic [1:0]    i_addr,
  input  logic [7:0]    i_data,
  output logic          o_ready,
  output logic          o_commit_ftw,
  output logic          o_commit_ofs,
  output logic [PW-1:0] o_word
);

  localparam int NB = PW / 8;
  localparam int CW = cnt_width(NB);

  logic [PW-1:0] r_shadow;
  logic [CW-1:0] r_cnt;
  logic          r_seq_ofs;
  logic          r_ready;

  logic          w_xfer;
  logic          w_word_tgt;
  logic          w_tgt_ofs;
  logic          w_abort;
  logic [CW-1:0] w_idx;
  logic          w_last;
  logic          w_commit;
  logic [PW-1:0] w_shifted;

  assign w_xfer     = i_valid && r_ready;
  assign w_word_tgt = (i_addr == CFG_FTW) || (i_addr == CFG_OFS);
  assign w_tgt_ofs  = (i_addr == CFG_OFS);

  // A byte for the other word target mid-sequence becomes byte 0 of that target.
  assign w_abort   = (r_cnt != '0) && (w_tgt_ofs != r_seq_ofs);
  assign w_idx     = w_abort ? '0 : r_cnt;
  assign w_last    = (w_idx == CW'(NB - 1));
  assign w_shifted = w_abort ? {i_data, {(PW-8){1'b0}}} : {i_data, r_shadow[PW-1:8]};
  assign w_commit  = w_xfer && w_word_tgt && w_last;

  assign o_ready      = r_ready;
  assign o_commit_ftw = w_commit && !w_tgt_ofs;
  assign o_commit_ofs = w_commit && w_tgt_ofs;
  assign o_word       = w_shifted;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow  <= '0;
      r_cnt     <= '0;
      r_seq_ofs <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_ready <= !w_commit;
      if (w_xfer && w_word_tgt) begin
        r_shadow  <= w_commit ? '0 : w_shifted;
        r_cnt     <= w_last ? '0 : w_idx + CW'(1);
        r_seq_ofs <= w_tgt_ofs;
      end
    end
  end

endmodule

// File: rtl/nco_phase_accum.sv
// Phase accumulator feeding cordic_nco: FTW/offset/sweep-step registers,
// saturating linear sweep on wrap, and a registered phase sample with flags.
module nco_phase_accum
  import nco_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [1:0]    cfg_addr,
  input  logic [7:0]    cfg_data,
  output logic [PW-1:0] o_phase,
  output logic          o_valid,
  output logic          o_wrap
);

  logic [PW-1:0] r_acc;
  logic [PW-1:0] r_ftw;
  logic [PW-1:0] r_ofs;
  logic [SW-1:0] r_step;
  logic          r_en;

  logic          w_commit_ftw;
  logic          w_commit_ofs;
  logic [PW-1:0] w_word;
  logic          w_xfer;
  logic          w_step_wr;
  logic          w_ctrl_wr;
  logic          w_clr;
  logic          w_adv;
  logic [PW:0]   w_sum;
  logic [PW-1:0] w_step_ext;
  logic [PW:0]   w_sweep_sum;
  logic [PW-1:0] w_swept;
  logic [PW-1:0] w_acc_next;
  logic          w_wrap;

  nco_cfg_loader #(.PW(PW)) u_loader (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (cfg_valid),
    .i_addr       (cfg_addr),
    .i_data       (cfg_data),
    .o_ready      (cfg_ready),
    .o_commit_ftw (w_commit_ftw),
    .o_commit_ofs (w_commit_ofs),
    .o_word       (w_word)
  );

  assign w_xfer    = cfg_valid && cfg_ready;
  assign w_step_wr = w_xfer && (cfg_addr == CFG_STEP);
  assign w_ctrl_wr = w_xfer && (cfg_addr == CFG_CTRL);
  assign w_clr     = w_ctrl_wr && cfg_data[CTRL_CLR];
  assign w_adv     = ce && r_en;

  assign w_sum = {1'b0, r_acc} + {1'b0, r_ftw};

  // Sign-extended add one bit wide: bit PW set means overflow for a positive
  // step and a negative result for a negative step.
  assign w_step_ext  = {{(PW-SW){r_step[SW-1]}}, r_step};
  assign w_sweep_sum = {1'b0, r_ftw} + {r_step[SW-1], w_step_ext};
  assign w_swept     = w_sweep_sum[PW] ? (r_step[SW-1] ? '0 : '1) : w_sweep_sum[PW-1:0];

  always_comb begin
    w_acc_next = r_acc;
    w_wrap     = 1'b0;
    if (w_clr) begin
      w_acc_next = '0;
    end else if (w_adv) begin
      w_acc_next = w_sum[PW-1:0];
      w_wrap     = w_sum[PW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc   <= '0;
      r_ftw   <= '0;
      r_ofs   <= '0;
      r_step  <= '0;
      r_en    <= 1'b0;
      o_phase <= '0;
      o_valid <= 1'b0;
      o_wrap  <= 1'b0;
    end else begin
      r_acc <= w_acc_next;
      if (w_commit_ftw) begin
        r_ftw <= w_word;
      end else if (w_wrap) begin
        r_ftw <= w_swept;
      end
      if (w_commit_ofs) r_ofs <= w_word;
      if (w_step_wr) r_step <= cfg_data[SW-1:0];
      if (w_ctrl_wr) r_en <= cfg_data[CTRL_EN];
      o_valid <= w_adv;
      if (w_adv) begin
        o_phase <= w_acc_next + r_ofs;
        o_wrap  <= w_wrap;
      end
    end
  end

endmodule

// File: doc/nco_phase_accum.md
Name: nco_phase_accum

Overview:
- Numerically-controlled phase generator sitting directly upstream of cordic_nco; drives its 24-bit i_phase input.
- Holds a frequency tuning word (FTW), a phase offset and an optional linear-sweep step, all loaded through a byte-wide config port fed from the 8-bit pin interface.
- Produces one registered phase sample per enabled clock, plus valid and wrap flags.

Parameters:
- PW, 24, phase and FTW width in bits; must be a multiple of 8 (NB = PW/8 config bytes per word).
- SW, 8, sweep step width in bits, signed.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  clock enable (tied to ena); accumulator advances only when high
- cfg_valid  in  1  config byte strobe
- cfg_ready  out  1  config port can accept a byte
- cfg_addr  in  2  target: 0=FTW, 1=offset, 2=sweep step, 3=control
- cfg_data  in  8  config byte
- o_phase  out  PW  phase sample (accumulator + offset), to cordic_nco i_phase
- o_valid  out  1  o_phase updated this cycle
- o_wrap  out  1  accumulator overflowed on the step that produced o_phase

Behaviour:
- Reset clears acc, ftw, offset, step, shadow, byte counter, enable, o_phase, o_valid and o_wrap to 0. cfg_ready resets to 1.
- Config transfer occurs when cfg_valid && cfg_ready.
- Addr 0/1 (word targets):
  - Each byte shifts into a PW-bit shadow register LSB-first; a byte counter tracks 0..NB-1.
  - On byte NB-1, the shadow is committed to ftw or offset on the same clock edge. The counter returns to 0.
  - cfg_ready drops for exactly the cycle after a commit, then returns to 1.
  - A transfer whose cfg_addr differs from the addr of the in-progress sequence discards the partial shadow. The counter restarts, and that byte becomes byte 0 of the new target.
- Addr 2: step <= cfg_data (signed SW), takes effect immediately; no counter involvement.
- Addr 3: bit0 = enable (level, held); bit1 = clear_phase (pulse: acc <= 0 next edge, not stored); bits 7:2 ignored.
- Accumulator, when ce && enable:
  - acc <= (acc + ftw) mod 2^PW.
  - wrap = carry-out of that add.
- Sweep: on a cycle where wrap=1, ftw <= ftw + sign-extend(step).
  - Saturates at 0 and at 2^PW-1; no wrap-around.
- Priority on ftw: FTW commit overrides sweep update in the same cycle.
- clear_phase overrides accumulation in the same cycle (acc <= 0). That cycle still produces o_valid=1 with o_phase = offset and o_wrap=0.
- Output register, updated when ce && enable:
  - o_phase <= acc_next + offset, mod 2^PW.
  - o_wrap <= wrap.
- o_valid <= ce && enable, every cycle.
- Latency: new FTW or offset affects o_phase at the first enabled edge after commit (1 cycle).
- When ce or enable is low: o_phase and o_wrap hold, o_valid=0, acc holds. The config port remains fully functional regardless of ce.
- Reset asserted mid-sequence: partial shadow is lost and all state returns to reset values on that edge.

Decomposition:
- Shared package nco_pkg:
  - PW and SW defaults.
  - cfg_addr encodings CFG_FTW=0, CFG_OFS=1, CFG_STEP=2, CFG_CTRL=3.
  - Control bit indices CTRL_EN=0, CTRL_CLR=1.
- One natural sub-module, nco_cfg_loader: byte counter, shadow shift register, addr-change abort and commit/ready logic. It outputs commit_ftw, commit_ofs and the shadow value.
- Accumulator, sweep and output register stay in the top.

Test Plan:
- Reset, then bytes 0x00,0x00,0x01 to addr 0, then 0x01 to addr 3 with ce=1 -> ftw=0x010000; o_phase = 0x010000, 0x020000, ... on consecutive cycles; o_valid=1; cfg_ready low exactly one cycle after the third byte.
- ftw=0x400000, offset bytes 0x00,0x00,0x80 -> o_phase sequence 0xC00000, 0x000000, 0x400000; o_wrap=1 on the sample where acc goes 0xC00000->0x000000.
- Send 2 bytes to addr 0, then 1 byte to addr 1, then 2 more bytes to addr 1 -> ftw unchanged; offset committed from the 3 addr-1 bytes.
- ftw=0xFFFFF0, step=0x7F, enable -> ftw saturates at 0xFFFFFF after the first wrap. Then step=0x80 with ftw=0x000010 -> ftw saturates at 0 after the first wrap, and o_phase freezes (acc constant).
- Toggle ce 1,0,0,1 while enabled with ftw=0x000100 -> o_valid follows ce delayed by one cycle; o_phase advances by 0x100 only on ce cycles; write 0x03 to addr 3 -> next o_phase equals offset.
- Assert reset after the 2nd FTW byte -> all outputs 0 next cycle, cfg_ready=1; a following 3-byte load commits correctly.
